regfile_wb_scheduler: RTL
=========================

Name: regfile_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 register file (x0 hardwired zero) between two writeback sources: ALU (req0) and LSU (req1).
- Round-robin arbitration with valid/ready handshake on each source; the winning write is registered and driven to the regfile write port one cycle later.
- Holds a pending-write scoreboard: set at instruction issue, cleared after the regfile write commits. Decode queries it for rs1/rs2 hazards.

Parameters:
DATA_WIDTH, 32, width of writeback data
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_rd  in  ADDR_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU request granted this cycle
lsu_rd  in  ADDR_WIDTH  LSU destination register
lsu_data  in  DATA_WIDTH  load data
issue_valid  in  1  instruction with destination issued this cycle
issue_rd  in  ADDR_WIDTH  destination of issued instruction
rs1_addr  in  ADDR_WIDTH  hazard query address 1
rs2_addr  in  ADDR_WIDTH  hazard query address 2
rs1_busy  out  1  write pending to rs1_addr
rs2_busy  out  1  write pending to rs2_addr
busy_vec  out  NUM_REGS  full scoreboard
we  out  1  regfile write enable
rd_addr  out  ADDR_WIDTH  regfile write address
wdata  out  DATA_WIDTH  regfile write data

Behaviour:
- Reset (async, rst=1): we=0, rd_addr=0, wdata=0, busy_vec=0, rr_last=LSU (ALU wins the first tie). alu_ready and lsu_ready are combinational and evaluate to 0 while nothing is valid.
- Arbitration is combinational each cycle:
  - Only one source valid: that source gets ready=1.
  - Both valid: the source not granted last gets ready=1; the other gets 0.
  - At most one ready is high in any cycle.
  - No backpressure from the regfile, so some valid source is always granted.
- A transfer occurs when valid&ready at a posedge. rr_last updates to the granted source only on a transfer.
- A non-granted source holds valid, rd and data stable until granted. The bench checks this; the RTL does not enforce it.
- Output register loads at the transfer edge:
  - we = (granted rd != 0); rd_addr and wdata = granted rd and data.
  - An rd=0 transfer is accepted (ready=1) but produces we=0, i.e. it is silently dropped.
  - No transfer that edge: we=0. rd_addr and wdata hold their previous values.
- Latency: request accepted at edge N; we high during cycle N..N+1; the regfile captures the write at edge N+1.
- Scoreboard:
  - Set: issue_valid at an edge with issue_rd != 0 sets busy[issue_rd].
  - Clear: at each edge where we=1, busy[rd_addr] clears, so busy drops only after the regfile holds the new value.
  - Set and clear of the same index at the same edge: set wins (new producer issued).
  - busy[0] is always 0; issue_rd=0 is ignored.
  - rsN_busy = busy_vec[rsN_addr], combinational, with no bypass of same-cycle set/clear.
  - A writeback to a non-busy register still writes; no error is raised.
- Reset asserted mid-operation clears we, busy_vec and rr_last immediately (asynchronously). Any in-flight registered write is lost.

Test Plan:
- Reset: rst=1 with alu_valid=1 -> we=0, busy_vec=0, alu_ready=0 while rst=1. Release rst; next edge transfers ALU.
- Single write: issue_valid with issue_rd=1; next cycle alu_valid, alu_rd=1, alu_data=0xADCBECAF -> alu_ready=1, we=1/rd_addr=1/wdata=0xADCBECAF next cycle. rs1_addr=1 reads busy=1 until the edge ending the we cycle, then 0.
- Contention: both valid for 4 cycles, alu_rd=2 (0xFDACBDAC), lsu_rd=3 (0x12345678), each source dropping valid once granted then re-asserting -> grant order ALU, LSU, ALU, LSU. we pulses with the matching rd/data each following cycle.
- x0: lsu_valid, lsu_rd=0, lsu_data=0xFFFFFFFF -> lsu_ready=1, we stays 0. issue_rd=0 leaves busy_vec=0.
- Set/clear collision: busy[5]=1 and a write to x5 committing (we=1, rd_addr=5) at the same edge as issue_valid/issue_rd=5 -> busy[5] remains 1 after the edge.
- Async reset mid-write: assert rst while we=1 and busy_vec=0x0000_0026 -> we=0 and busy_vec=0 before the next clk edge.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Regfile writeback scheduler: round-robin arbitration of ALU/LSU writebacks onto the
// single regfile write port, plus a pending-write scoreboard for decode hazard checks.
module regfile_wb_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] wdata
);

    localparam logic RR_ALU = 1'b0;
    localparam logic RR_LSU = 1'b1;

    logic                  r_rr_last;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_alu_gnt;
    logic                  w_lsu_gnt;
    logic [ADDR_WIDTH-1:0] w_gnt_rd;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    // Grants are gated by rst so neither source sees ready while reset is held.
    always_comb begin
        w_alu_gnt  = !rst && alu_valid && (!lsu_valid || (r_rr_last == RR_LSU));
        w_lsu_gnt  = !rst && lsu_valid && (!alu_valid || (r_rr_last == RR_ALU));
        w_gnt_rd   = w_alu_gnt ? alu_rd   : lsu_rd;
        w_gnt_data = w_alu_gnt ? alu_data : lsu_data;
    end

    // Clear is applied before set so a newly issued producer keeps the entry busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= RR_LSU;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_wdata   <= '0;
            r_busy    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_alu_gnt || w_lsu_gnt) begin
                r_rr_last <= w_alu_gnt ? RR_ALU : RR_LSU;
                r_we      <= (w_gnt_rd != '0);
                r_rd      <= w_gnt_rd;
                r_wdata   <= w_gnt_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign alu_ready = w_alu_gnt;
    assign lsu_ready = w_lsu_gnt;
    assign rs1_busy  = r_busy[rs1_addr];
    assign rs2_busy  = r_busy[rs2_addr];
    assign busy_vec  = r_busy;
    assign we        = r_we;
    assign rd_addr   = r_rd;
    assign wdata     = r_wdata;

endmodule
